aes_block_packer: RTL and testbench

Byte-stream to AES-block packer sitting directly upstream of `enc_aes`. It collects plaintext bytes from the compression/byte pipeline into 128-bit blocks and applies PKCS#7 padding at end of message. Each finished block is presented with a valid/ready handshake, and `blk_data` is held stable so it can drive the 128-bit input of `enc_aes`.

---
 rtl/aes_pkg.sv | 14 +
 rtl/pkcs7_pad_fill.sv | 21 ++
 rtl/aes_block_packer.sv | 94 +++++++++
 tb/tb_aes_block_packer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES block constants and types for the byte-to-block packer.
package aes_pkg;
  localparam int AES_BLOCK_BITS  = 128;
  localparam int AES_BLOCK_BYTES = 16;

  typedef enum logic [1:0] {FILL, PAD, EMIT} packer_state_t;

  // Pad/fill byte count, 0..16.
  typedef logic [4:0] pad_cnt_t;

  function automatic pad_cnt_t pad_count(input logic [3:0] cnt);
    return pad_cnt_t'(5'd16 - {1'b0, cnt});
  endfunction
endpackage

// File: rtl/pkcs7_pad_fill.sv
// Combinational tail fill: bytes cnt..15 get PKCS#7 pad value (or zero).
module pkcs7_pad_fill
  import aes_pkg::*;
(
  input  logic [AES_BLOCK_BITS-1:0] blk,
  input  logic [3:0]                cnt,
  input  logic                      pad_en,
  output logic [AES_BLOCK_BITS-1:0] filled,
  output pad_cnt_t                  pad
);
  logic [7:0] fill_byte;

  assign pad       = pad_count(cnt);
  // cnt==0 yields pad=16, i.e. a full block of 0x10.
  assign fill_byte = pad_en ? {3'b000, pad} : 8'h00;

  for (genvar i = 0; i < AES_BLOCK_BYTES; i++) begin : g_byte
    localparam int HI = AES_BLOCK_BITS - 1 - 8 * i;
    assign filled[HI -: 8] = (4'(i) >= cnt) ? fill_byte : blk[HI -: 8];
  end
endmodule

// File: rtl/aes_block_packer.sv
// Packs a plaintext byte stream into 128-bit blocks with PKCS#7 or zero padding.
module aes_block_packer
  import aes_pkg::*;
#(
  parameter bit PAD_EN = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                in_data,
  input  logic                      in_valid,
  input  logic                      in_last,
  output logic                      in_ready,
  output logic [AES_BLOCK_BITS-1:0] blk_data,
  output logic                      blk_valid,
  input  logic                      blk_ready,
  output logic                      blk_last,
  output logic [4:0]                blk_pad
);
  packer_state_t             state, state_nxt;
  logic [3:0]                cnt;
  logic [AES_BLOCK_BITS-1:0] data;
  logic [AES_BLOCK_BITS-1:0] filled;
  pad_cnt_t                  fill_pad;
  logic                      extra_pad;
  logic                      byte_xfer, blk_xfer;

  // Handshake flags decode from the state register only.
  assign in_ready  = (state == FILL);
  assign blk_valid = (state == EMIT);
  assign blk_data  = data;
  assign byte_xfer = in_valid & in_ready;
  assign blk_xfer  = blk_valid & blk_ready;

  pkcs7_pad_fill u_fill (
    .blk    (data),
    .cnt    (cnt),
    .pad_en (PAD_EN),
    .filled (filled),
    .pad    (fill_pad)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL: begin
        if (byte_xfer && cnt == 4'd15) state_nxt = EMIT;
        else if (byte_xfer && in_last) state_nxt = PAD;
      end
      PAD:  state_nxt = EMIT;
      EMIT: if (blk_xfer) state_nxt = extra_pad ? PAD : FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      data      <= '0;
      extra_pad <= 1'b0;
      blk_last  <= 1'b0;
      blk_pad   <= '0;
    end else begin
      case (state)
        FILL: if (byte_xfer) begin
          for (int i = 0; i < AES_BLOCK_BYTES; i++)
            if (cnt == 4'(i)) data[AES_BLOCK_BITS-1-8*i -: 8] <= in_data;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            // A full final block under PKCS#7 still owes a whole pad block.
            blk_last  <= in_last & ~PAD_EN;
            blk_pad   <= '0;
            extra_pad <= in_last & PAD_EN;
          end
        end
        PAD: begin
          data     <= filled;
          blk_pad  <= fill_pad;
          blk_last <= 1'b1;
        end
        EMIT: if (blk_xfer) begin
          cnt <= '0;
          if (extra_pad) extra_pad <= 1'b0;
          else           data      <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_block_packer.sv
// Bench for aes_block_packer: directed plan steps plus random messages vs a block model.
module tb_aes_block_packer;
  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [127:0] data;
    logic         last;
    logic [4:0]   pad;
  } blk_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   in_data   [2];
  logic         in_valid  [2];
  logic         in_last   [2];
  logic         in_ready  [2];
  logic [127:0] blk_data  [2];
  logic         blk_valid [2];
  logic         blk_ready [2];
  logic         blk_last  [2];
  logic [4:0]   blk_pad   [2];

  // Instance 0 uses PKCS#7 padding, instance 1 zero-fills.
  aes_block_packer #(.PAD_EN(1'b1)) dut_pad (
    .clk(clk), .rst(rst), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_last(in_last[0]), .in_ready(in_ready[0]), .blk_data(blk_data[0]),
    .blk_valid(blk_valid[0]), .blk_ready(blk_ready[0]), .blk_last(blk_last[0]),
    .blk_pad(blk_pad[0]));

  aes_block_packer #(.PAD_EN(1'b0)) dut_zero (
    .clk(clk), .rst(rst), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_last(in_last[1]), .in_ready(in_ready[1]), .blk_data(blk_data[1]),
    .blk_valid(blk_valid[1]), .blk_ready(blk_ready[1]), .blk_last(blk_last[1]),
    .blk_pad(blk_pad[1]));

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   xfers [2] = '{0, 0};
  blk_t q0[$];
  blk_t q1[$];
  bit   rand_ready = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  function automatic int qsize(input int s);
    return (s == 0) ? q0.size() : q1.size();
  endfunction

  task automatic push(input int s, input blk_t b);
    if (s == 0) q0.push_back(b);
    else        q1.push_back(b);
  endtask

  // Reference: split the message into 16-byte chunks, pad the tail chunk.
  task automatic expect_msg(input int s, input bq_t msg);
    int n = msg.size();
    int i = 0;
    bit pe = (s == 0);
    while (i < n) begin
      int           len;
      blk_t         b;
      logic [127:0] d;
      len = (n - i >= 16) ? 16 : n - i;
      d   = '0;
      for (int k = 0; k < 16; k++)
        d = {d[119:0], (k < len) ? msg[i+k] : (pe ? 8'(16 - len) : 8'h00)};
      i += len;
      b.data = d;
      b.pad  = 5'(16 - len);
      b.last = (i == n) && (len < 16 || !pe);
      push(s, b);
      if (i == n && len == 16 && pe) begin
        b.data = {16{8'h10}};
        b.last = 1'b1;
        b.pad  = 5'd16;
        push(s, b);
      end
    end
  endtask

  function automatic bq_t seq(input int start, input int n);
    bq_t q;
    for (int k = 0; k < n; k++) q.push_back(8'(start + k));
    return q;
  endfunction

  function automatic bq_t rnd(input int n);
    bq_t q;
    for (int k = 0; k < n; k++) q.push_back(8'($urandom));
    return q;
  endfunction

  // Drive bytes; inputs change 1 time unit after the rising edge.
  task automatic send(input int s, input bq_t msg, input bit mark_last, input bit gaps);
    for (int i = 0; i < msg.size(); i++) begin
      if (gaps)
        for (int g = $urandom_range(0, 2); g > 0; g--) begin
          in_valid[s] = 1'b0;
          in_last[s]  = 1'($urandom_range(0, 1));
          in_data[s]  = 8'($urandom);
          @(posedge clk); #1;
        end
      in_valid[s] = 1'b1;
      in_data[s]  = msg[i];
      in_last[s]  = mark_last && (i == msg.size() - 1);
      begin
        int w  = 0;
        bit ok = 1'b0;
        while (!ok && w < 200) begin
          @(negedge clk);
          ok = in_ready[s];
          @(posedge clk); #1;
          w++;
        end
        if (!ok) chkb("in_ready_timeout", ok, 1'b1);
      end
    end
    in_valid[s] = 1'b0;
    in_last[s]  = 1'b0;
  endtask

  task automatic drain(input int s);
    int w = 0;
    while (qsize(s) != 0 && w < 400) begin
      @(negedge clk);
      w++;
    end
    chkb("drain", qsize(s) == 0, 1'b1);
    @(posedge clk); #1;
  endtask

  // Monitor: every block transfer is compared with the next modelled block.
  always @(negedge clk) begin
    blk_t e;
    bit   have;
    for (int s = 0; s < 2; s++)
      if (!rst && blk_valid[s] && blk_ready[s]) begin
        have = (qsize(s) > 0);
        if (have) e = (s == 0) ? q0.pop_front() : q1.pop_front();
        xfers[s]++;
        chkb($sformatf("blk%0d_expected", s), have, 1'b1);
        if (have) begin
          chk($sformatf("blk%0d_data", s), blk_data[s], e.data);
          chkb($sformatf("blk%0d_last", s), blk_last[s], e.last);
          chk($sformatf("blk%0d_pad", s), 128'(blk_pad[s]), 128'(e.pad));
        end
      end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready)
      for (int s = 0; s < 2; s++) blk_ready[s] = ($urandom_range(0, 3) != 0);
  end

  initial begin
    bq_t          msg;
    logic [127:0] d_snap;
    logic         l_snap;
    logic [4:0]   p_snap;
    int           x0;

    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      in_data[s] = '0; in_valid[s] = 1'b0; in_last[s] = 1'b0; blk_ready[s] = 1'b1;
    end
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chkb("rst_in_ready", in_ready[s], 1'b1);
      chkb("rst_blk_valid", blk_valid[s], 1'b0);
      chkb("rst_blk_last", blk_last[s], 1'b0);
      chk("rst_blk_pad", 128'(blk_pad[s]), 128'(0));
      chk("rst_blk_data", blk_data[s], 128'(0));
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // 16-byte message: data block then a whole 0x10 pad block.
    msg = seq(0, 16);
    expect_msg(0, msg);
    send(0, msg, 1'b1, 1'b0);
    @(negedge clk);
    chkb("full_valid_next_cycle", blk_valid[0], 1'b1);
    drain(0);

    // 5-byte message: one PAD cycle, then the padded block.
    msg = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h11};
    expect_msg(0, msg);
    send(0, msg, 1'b1, 1'b0);
    @(negedge clk);
    chkb("pad_cycle_no_valid", blk_valid[0], 1'b0);
    chkb("pad_cycle_no_ready", in_ready[0], 1'b0);
    @(negedge clk);
    chkb("pad_valid_2_cycles", blk_valid[0], 1'b1);
    chk("pkcs7_5_bytes", blk_data[0], 128'h1111111111_0B0B0B0B0B0B0B0B0B0B0B);
    @(negedge clk);
    chkb("in_ready_after_xfer", in_ready[0], 1'b1);
    drain(0);

    // 20-byte message with input gaps and stray in_last while idle.
    msg = seq(0, 20);
    expect_msg(0, msg);
    send(0, msg, 1'b1, 1'b1);
    drain(0);

    // Backpressure: hold a full block for 10 cycles.
    msg = rnd(20);
    expect_msg(0, msg);
    blk_ready[0] = 1'b0;
    send(0, msg[0:15], 1'b0, 1'b0);
    @(negedge clk);
    chkb("bp_valid", blk_valid[0], 1'b1);
    d_snap = blk_data[0]; l_snap = blk_last[0]; p_snap = blk_pad[0];
    repeat (10) begin
      @(negedge clk);
      chk("bp_data_stable", blk_data[0], d_snap);
      chkb("bp_last_stable", blk_last[0], l_snap);
      chk("bp_pad_stable", 128'(blk_pad[0]), 128'(p_snap));
      chkb("bp_in_ready_low", in_ready[0], 1'b0);
    end
    @(posedge clk); #1;
    x0 = xfers[0];
    blk_ready[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk("bp_one_xfer", 128'(xfers[0] - x0), 128'(1));
    @(posedge clk); #1;
    send(0, msg[16:19], 1'b1, 1'b0);
    drain(0);

    // Zero-fill instance: 3-byte and 16-byte messages.
    msg = '{8'hAA, 8'hBB, 8'hCC};
    expect_msg(1, msg);
    send(1, msg, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    chk("zero_fill_3", blk_data[1], 128'hAABBCC00_00000000_00000000_00000000);
    drain(1);
    x0 = xfers[1];
    msg = rnd(16);
    expect_msg(1, msg);
    send(1, msg, 1'b1, 1'b0);
    drain(1);
    repeat (5) @(negedge clk);
    chk("zero_16_one_block", 128'(xfers[1] - x0), 128'(1));
    @(posedge clk); #1;

    // Reset while a padded block is stalled in EMIT.
    blk_ready[0] = 1'b0;
    send(0, seq(8'h60, 3), 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    chkb("emit_before_rst", blk_valid[0], 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chkb("rst_emit_valid", blk_valid[0], 1'b0);
    chkb("rst_emit_ready", in_ready[0], 1'b1);
    chkb("rst_emit_last", blk_last[0], 1'b0);
    chk("rst_emit_pad", 128'(blk_pad[0]), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    blk_ready[0] = 1'b1;

    // Reset after 7 bytes, then a clean 16-byte message.
    send(0, seq(0, 7), 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chkb("rst_mid_valid", blk_valid[0], 1'b0);
    chkb("rst_mid_ready", in_ready[0], 1'b1);
    chk("rst_mid_data", blk_data[0], 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    msg = seq(8'h20, 16);
    expect_msg(0, msg);
    send(0, msg, 1'b1, 1'b0);
    drain(0);

    // Random messages on both instances with random downstream stalls.
    rand_ready = 1'b1;
    for (int it = 0; it < 14; it++) begin
      int s;
      s = $urandom_range(0, 1);
      msg = rnd($urandom_range(1, 40));
      expect_msg(s, msg);
      send(s, msg, 1'b1, 1'b1);
    end
    drain(0);
    drain(1);
    rand_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
